// File: rtl/keypad_scan.sv
// 4x4 matrix keypad front end: row scan, 2-flop column sync, press/release debounce, key decode.
// Key event lands DEBOUNCE cycles after the detecting sample; the digit strobe follows one cycle later.
module keypad_scan #(
    parameter int SCAN_DIV = 256,
    parameter int DEBOUNCE = 1024
) (
    input  logic       clk,
    input  logic       nRST,
    output logic [3:0] row_out,
    input  logic [3:0] col_in,
    input  logic       complete,
    output logic [3:0] keypad_input,
    output logic       read_input,
    output logic [2:0] operator_input,
    output logic       equal_input
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} state_t;

    state_t        state_q, state_d;
    logic [3:0]    col_s1_q, col_s2_q;
    logic [1:0]    row_q, row_d;
    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [1:0]    lat_row_q, lat_row_d;
    logic [3:0]    lat_col_q, lat_col_d;
    logic [3:0]    kp_q, kp_d;
    logic          dig_ev_q, dig_ev_d;
    logic          read_q;
    logic [2:0]    op_q, op_d;
    logic          eq_q, eq_d;

    logic [3:0]    col_low;
    logic          one_low;
    logic          key_ev;
    logic [1:0]    col_idx;

    assign col_low = ~col_s2_q;
    assign one_low = (col_low != 4'd0) && ((col_low & (col_low - 4'd1)) == 4'd0);

    // Scan/debounce FSM; row rotation is frozen outside SCAN so the latched key stays driven.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        scan_cnt_d = scan_cnt_q;
        deb_cnt_d  = deb_cnt_q;
        lat_row_d  = lat_row_q;
        lat_col_d  = lat_col_q;
        key_ev     = 1'b0;
        case (state_q)
            SCAN: begin
                if (scan_cnt_q == SCAN_LAST) begin
                    scan_cnt_d = '0;
                    if (one_low) begin
                        lat_row_d = row_q;
                        lat_col_d = col_s2_q;
                        deb_cnt_d = DW'(1);
                        state_d   = DEB_PRESS;
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end else begin
                    scan_cnt_d = scan_cnt_q + SW'(1);
                end
            end
            DEB_PRESS: begin
                if (col_s2_q != lat_col_q) begin
                    deb_cnt_d = '0;
                    state_d   = SCAN;
                end else if (deb_cnt_q >= DEB_LAST) begin
                    key_ev    = 1'b1;
                    deb_cnt_d = '0;
                    state_d   = HELD;
                end else begin
                    deb_cnt_d = deb_cnt_q + DW'(1);
                end
            end
            HELD: begin
                if (col_s2_q == 4'hF) begin
                    deb_cnt_d = DW'(1);
                    state_d   = DEB_REL;
                end
            end
            DEB_REL: begin
                if (col_s2_q != 4'hF) begin
                    deb_cnt_d = '0;
                    state_d   = HELD;
                end else if (deb_cnt_q >= DEB_LAST) begin
                    deb_cnt_d = '0;
                    state_d   = SCAN;
                end else begin
                    deb_cnt_d = deb_cnt_q + DW'(1);
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_comb begin
        col_idx = 2'd0;
        casez (lat_col_q)
            4'b???0: col_idx = 2'd0;
            4'b??01: col_idx = 2'd1;
            4'b?011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: col_idx = 2'd0;
        endcase
    end

    // Completion is applied before key decode; a key event while equals is pending is dropped.
    always_comb begin
        kp_d     = kp_q;
        dig_ev_d = 1'b0;
        op_d     = op_q;
        eq_d     = eq_q;
        if (eq_q && complete) begin
            eq_d = 1'b0;
            op_d = 3'b000;
        end
        if (key_ev && !eq_q) begin
            if (lat_row_q != 2'd3) begin
                if (col_idx != 2'd3) begin
                    kp_d     = {2'b00, lat_row_q} * 4'd3 + {2'b00, col_idx} + 4'd1;
                    dig_ev_d = 1'b1;
                end else begin
                    op_d = 3'b001 << lat_row_q;
                end
            end else if (col_idx == 2'd1) begin
                kp_d     = 4'd0;
                dig_ev_d = 1'b1;
            end else if (col_idx == 2'd2) begin
                eq_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nRST) begin
            state_q    <= SCAN;
            col_s1_q   <= 4'hF;
            col_s2_q   <= 4'hF;
            row_q      <= 2'd0;
            scan_cnt_q <= '0;
            deb_cnt_q  <= '0;
            lat_row_q  <= 2'd0;
            lat_col_q  <= 4'hF;
            kp_q       <= 4'd0;
            dig_ev_q   <= 1'b0;
            read_q     <= 1'b0;
            op_q       <= 3'b000;
            eq_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_s1_q   <= col_in;
            col_s2_q   <= col_s1_q;
            row_q      <= row_d;
            scan_cnt_q <= scan_cnt_d;
            deb_cnt_q  <= deb_cnt_d;
            lat_row_q  <= lat_row_d;
            lat_col_q  <= lat_col_d;
            kp_q       <= kp_d;
            dig_ev_q   <= dig_ev_d;
            read_q     <= dig_ev_q;
            op_q       <= op_d;
            eq_q       <= eq_d;
        end
    end

    assign row_out        = ~(4'b0001 << row_q);
    assign keypad_input   = kp_q;
    assign read_input     = read_q;
    assign operator_input = op_q;
    assign equal_input    = eq_q;
endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a behavioural 4x4 key matrix (SCAN_DIV=4, DEBOUNCE=8).
module tb_keypad_scan;
    logic       clk = 1'b0;
    logic       nRST;
    logic [3:0] row_out;
    logic [3:0] col_in;
    logic       complete;
    logic [3:0] keypad_input;
    logic       read_input;
    logic [2:0] operator_input;
    logic       equal_input;

    always #5 clk = ~clk;

    keypad_scan #(.SCAN_DIV(4), .DEBOUNCE(8)) dut (
        .clk(clk),
        .nRST(nRST),
        .row_out(row_out),
        .col_in(col_in),
        .complete(complete),
        .keypad_input(keypad_input),
        .read_input(read_input),
        .operator_input(operator_input),
        .equal_input(equal_input)
    );

    int         key_r = 0, key_c = 0, key2_r = 0, key2_c = 0;
    logic       key_dn = 1'b0, key2_dn = 1'b0;
    logic [3:0] col_force = 4'b0000;

    // Pressed key shorts its column to its row; rows and columns are active-low.
    always_comb begin
        col_in = 4'hF;
        if (key_dn && !row_out[key_r]) col_in[key_c] = 1'b0;
        if (key2_dn && !row_out[key2_r]) col_in[key2_c] = 1'b0;
        col_in = col_in & ~col_force;
    end

    int         pulse_cnt = 0, dbl_cnt = 0, unstable_cnt = 0;
    logic       prev_rd = 1'b0;
    logic [3:0] prev_kp = 4'd0;

    always @(negedge clk) begin
        if (read_input === 1'b1) begin
            pulse_cnt <= pulse_cnt + 1;
            if (prev_rd) dbl_cnt <= dbl_cnt + 1;
            if (keypad_input !== prev_kp) unstable_cnt <= unstable_cnt + 1;
        end
        prev_rd <= read_input;
        prev_kp <= keypad_input;
    end

    int tests = 0, fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int r, input int c, input int hold);
        key_r  = r;
        key_c  = c;
        key_dn = 1'b1;
        tick(hold);
        key_dn = 1'b0;
        tick(40);
    endtask

    typedef struct {
        int         r;
        int         c;
        logic [3:0] kp;
        int         pulses;
        logic [2:0] op;
        logic       eq;
    } vec_t;

    vec_t vecs[15];
    int   p0, first_kp, first_rd;
    logic rd_at_kp;

    initial begin
        vecs[0]  = '{0, 0, 4'd1, 1, 3'b000, 1'b0};
        vecs[1]  = '{0, 3, 4'd1, 0, 3'b001, 1'b0};
        vecs[2]  = '{0, 1, 4'd2, 1, 3'b001, 1'b0};
        vecs[3]  = '{1, 3, 4'd2, 0, 3'b010, 1'b0};
        vecs[4]  = '{2, 3, 4'd2, 0, 3'b100, 1'b0};
        vecs[5]  = '{3, 1, 4'd0, 1, 3'b100, 1'b0};
        vecs[6]  = '{2, 2, 4'd9, 1, 3'b100, 1'b0};
        vecs[7]  = '{3, 0, 4'd9, 0, 3'b100, 1'b0};
        vecs[8]  = '{3, 3, 4'd9, 0, 3'b100, 1'b0};
        vecs[9]  = '{1, 2, 4'd6, 1, 3'b100, 1'b0};
        vecs[10] = '{2, 0, 4'd7, 1, 3'b100, 1'b0};
        vecs[11] = '{1, 0, 4'd4, 1, 3'b100, 1'b0};
        vecs[12] = '{0, 2, 4'd3, 1, 3'b100, 1'b0};
        vecs[13] = '{2, 1, 4'd8, 1, 3'b100, 1'b0};
        vecs[14] = '{0, 3, 4'd8, 0, 3'b001, 1'b0};

        // Reset with column 2 held low, then watch the rotation including the wrap.
        nRST      = 1'b0;
        complete  = 1'b0;
        col_force = 4'b0100;
        tick(3);
        check("rst_row", 32'(row_out), 32'hE);
        check("rst_kp", 32'(keypad_input), 32'h0);
        check("rst_rd", 32'(read_input), 32'h0);
        check("rst_op", 32'(operator_input), 32'h0);
        check("rst_eq", 32'(equal_input), 32'h0);
        nRST      = 1'b1;
        col_force = 4'b0000;
        tick(3);
        check("rot_dwell", 32'(row_out), 32'h E);
        tick(1);
        check("rot_r1", 32'(row_out), 32'h D);
        tick(8);
        check("rot_r3", 32'(row_out), 32'h7);
        tick(4);
        check("rot_wrap", 32'(row_out), 32'h E);

        // Clean press of 5 from a known scan phase: exact event and strobe cycles.
        nRST = 1'b0;
        tick(2);
        nRST     = 1'b1;
        key_r    = 1;
        key_c    = 1;
        key_dn   = 1'b1;
        p0       = pulse_cnt;
        first_kp = -1;
        first_rd = -1;
        rd_at_kp = 1'bx;
        for (int k = 0; k < 200; k++) begin
            tick(1);
            if (first_kp < 0 && keypad_input == 4'd5) begin
                first_kp = k;
                rd_at_kp = read_input;
            end
            if (first_rd < 0 && read_input == 1'b1) first_rd = k;
        end
        key_dn = 1'b0;
        tick(40);
        check("lat_event", 32'(first_kp), 32'd14);
        check("lat_strobe", 32'(first_rd), 32'd15);
        check("lat_rd_at_e", 32'(rd_at_kp), 32'h0);
        check("clean_pulses", 32'(pulse_cnt - p0), 32'd1);
        check("clean_kp", 32'(keypad_input), 32'h5);

        // Bouncing contact on key 5, then a stable press.
        p0 = pulse_cnt;
        key_r = 1;
        key_c = 1;
        for (int i = 0; i < 20; i++) begin
            key_dn = ~key_dn;
            tick(3);
        end
        key_dn = 1'b0;
        tick(20);
        check("bounce_pulses", 32'(pulse_cnt - p0), 32'd0);
        press(1, 1, 60);
        check("bounce_then_hold", 32'(pulse_cnt - p0), 32'd1);
        check("bounce_kp", 32'(keypad_input), 32'h5);

        for (int i = 0; i < 15; i++) begin
            p0 = pulse_cnt;
            press(vecs[i].r, vecs[i].c, 60);
            check($sformatf("vec%0d_kp", i), 32'(keypad_input), 32'(vecs[i].kp));
            check($sformatf("vec%0d_pulses", i), 32'(pulse_cnt - p0), 32'(vecs[i].pulses));
            check($sformatf("vec%0d_op", i), 32'(operator_input), 32'(vecs[i].op));
            check($sformatf("vec%0d_eq", i), 32'(equal_input), 32'(vecs[i].eq));
        end

        // Equals, then lockout of a digit, a second equals and an operator.
        press(3, 2, 60);
        check("eq_set", 32'(equal_input), 32'h1);
        check("eq_op_kept", 32'(operator_input), 32'h1);
        p0 = pulse_cnt;
        press(2, 0, 60);
        check("lock_digit_pulses", 32'(pulse_cnt - p0), 32'd0);
        check("lock_digit_kp", 32'(keypad_input), 32'h8);
        press(3, 2, 60);
        check("lock_eq_again", 32'(equal_input), 32'h1);
        press(2, 3, 60);
        check("lock_op", 32'(operator_input), 32'h1);
        tick(20);
        complete = 1'b1;
        check("cmp_eq_before", 32'(equal_input), 32'h1);
        tick(1);
        check("cmp_eq_clear", 32'(equal_input), 32'h0);
        check("cmp_op_clear", 32'(operator_input), 32'h0);
        complete = 1'b0;
        tick(5);
        check("cmp_eq_stays", 32'(equal_input), 32'h0);

        // complete without a pending equals must not touch the operator.
        press(1, 3, 60);
        check("idle_cmp_op_set", 32'(operator_input), 32'h2);
        complete = 1'b1;
        tick(3);
        complete = 1'b0;
        tick(1);
        check("idle_cmp_op", 32'(operator_input), 32'h2);
        check("idle_cmp_eq", 32'(equal_input), 32'h0);

        // Two columns low on row 0.
        p0      = pulse_cnt;
        key_r   = 0;
        key_c   = 0;
        key2_r  = 0;
        key2_c  = 1;
        key_dn  = 1'b1;
        key2_dn = 1'b1;
        tick(60);
        key_dn  = 1'b0;
        key2_dn = 1'b0;
        tick(40);
        check("multi_pulses", 32'(pulse_cnt - p0), 32'd0);
        check("multi_kp", 32'(keypad_input), 32'h8);

        // Reset lands while key 9 is being debounced.
        nRST = 1'b0;
        tick(2);
        nRST   = 1'b1;
        key_r  = 2;
        key_c  = 2;
        key_dn = 1'b1;
        p0     = pulse_cnt;
        tick(13);
        nRST   = 1'b0;
        key_dn = 1'b0;
        tick(1);
        check("abort_row", 32'(row_out), 32'h E);
        check("abort_kp", 32'(keypad_input), 32'h0);
        check("abort_op", 32'(operator_input), 32'h0);
        check("abort_eq", 32'(equal_input), 32'h0);
        tick(1);
        nRST = 1'b1;
        tick(40);
        check("abort_pulses", 32'(pulse_cnt - p0), 32'd0);
        check("abort_kp_after", 32'(keypad_input), 32'h0);
        press(2, 2, 60);
        check("fresh_kp", 32'(keypad_input), 32'h9);
        check("fresh_pulses", 32'(pulse_cnt - p0), 32'd1);

        check("strobe_back_to_back", 32'(dbl_cnt), 32'd0);
        check("kp_unstable_at_strobe", 32'(unstable_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
